// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the systolic MAC processing element.
package pe_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_PASS  = 2'd3
    } pe_state_e;

    // Widest accumulator the helpers support; callers pass their true width.
    localparam int unsigned ACC_W_MAX = 64;

    typedef logic signed [ACC_W_MAX:0]   wide_t;
    typedef logic signed [ACC_W_MAX-1:0] acc_max_t;

    // Largest positive value of an acc_w-bit signed accumulator.
    function automatic wide_t smax(input int unsigned acc_w);
        wide_t v;
        v = '0;
        v[acc_w-1] = 1'b1;
        return v - wide_t'(1);
    endfunction

    // Most negative value of an acc_w-bit signed accumulator.
    function automatic wide_t smin(input int unsigned acc_w);
        wide_t v;
        v = '0;
        v[acc_w-1] = 1'b1;
        return -v;
    endfunction

    // Add two sign-extended acc_w-bit values; returns {ovf, result}, saturating or wrapping.
    function automatic logic [ACC_W_MAX:0] sat_add(input acc_max_t acc, input acc_max_t addend,
                                                   input int unsigned acc_w, input logic sat);
        wide_t       sum;
        acc_max_t    res;
        logic        ovf;
        int unsigned sh;
        sum = wide_t'(acc) + wide_t'(addend);
        ovf = (sum > smax(acc_w)) || (sum < smin(acc_w));
        sh  = ACC_W_MAX - acc_w;
        res = acc_max_t'(sum);
        if (ovf && sat) begin
            res = (sum < 0) ? acc_max_t'(smin(acc_w)) : acc_max_t'(smax(acc_w));
        end else if (ovf) begin
            // Keep the low acc_w bits and re-sign-extend them.
            res = res << sh;
            res = res >>> sh;
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/systolic_mac_pe_mul.sv
// Pipelined signed multiplier; valid and keep tags travel with each product.
module pe_mul_pipe #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    input  logic                       fire,
    input  logic                       keep,
    output logic signed [2*DATA_W-1:0] prod,
    output logic                       prod_vld,
    output logic                       prod_keep
);
    localparam int unsigned PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod_q [MUL_STAGES];
    logic [MUL_STAGES-1:0]   vld_q;
    logic [MUL_STAGES-1:0]   keep_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            keep_q <= '0;
            for (int i = 0; i < int'(MUL_STAGES); i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            prod_q[0] <= PW'(a) * PW'(b);
            vld_q[0]  <= fire;
            keep_q[0] <= keep;
            for (int i = 1; i < int'(MUL_STAGES); i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
                keep_q[i] <= keep_q[i-1];
            end
        end
    end

    assign prod      = prod_q[MUL_STAGES-1];
    assign prod_vld  = vld_q[MUL_STAGES-1];
    assign prod_keep = keep_q[MUL_STAGES-1];

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary signed MAC PE with saturating accumulator and column shift-chain drain.
module systolic_mac_pe
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned SAT        = 1,
    parameter int unsigned CHAIN_HEAD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    input  logic              clr,
    input  logic              drain_req,
    input  logic [ACC_W-1:0]  ps_in,
    input  logic              ps_vld_in,
    input  logic              ps_last_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    output logic [ACC_W-1:0]  ps_out,
    output logic              ps_vld_out,
    output logic              ps_last_out,
    output logic              busy,
    output logic              ovf
);
    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    pe_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_d;
    logic [ACC_W-1:0]        ps_d;
    logic                    ps_vld_d, ps_last_d;

    logic signed [PW-1:0]    prod;
    logic                    prod_vld, prod_keep;
    logic                    consume;
    logic                    sum_ovf;
    acc_max_t                sum_wide;

    // Products fired while flushing are tagged so they are dropped at the pipe exit.
    pe_mul_pipe #(
        .DATA_W     (DATA_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .a         ($signed(a_in)),
        .b         ($signed(b_in)),
        .fire      (a_vld_in & b_vld_in),
        .keep      (state_q != ST_FLUSH),
        .prod      (prod),
        .prod_vld  (prod_vld),
        .prod_keep (prod_keep)
    );

    assign {sum_ovf, sum_wide} = sat_add(acc_max_t'(acc_q), acc_max_t'(prod), ACC_W, SAT != 0);
    assign consume = prod_vld && prod_keep && (state_q == ST_ACC || state_q == ST_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus next values of every datapath register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_d     = ovf;
        ps_d      = ps_out;
        ps_vld_d  = 1'b0;
        ps_last_d = 1'b0;

        if (consume) begin
            acc_d = ACC_W'(sum_wide);
            if (sum_ovf) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            ST_ACC: begin
                if (clr) begin
                    acc_d = consume ? ACC_W'(prod) : '0;
                    ovf_d = 1'b0;
                end
                if (drain_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(MUL_STAGES - 1);
                end
            end
            ST_FLUSH: begin
                // Result is launched on the edge that retires the last in-flight product.
                if (cnt_q == '0) begin
                    ps_d      = acc_d;
                    ps_vld_d  = 1'b1;
                    ps_last_d = (CHAIN_HEAD != 0);
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = ST_EMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EMIT, ST_PASS: begin
                if (CHAIN_HEAD != 0) begin
                    state_d = ST_ACC;
                end else begin
                    ps_d      = ps_in;
                    ps_vld_d  = ps_vld_in;
                    ps_last_d = ps_last_in;
                    state_d   = (ps_vld_in && ps_last_in) ? ST_ACC : ST_PASS;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out       <= '0;
            a_vld_out   <= 1'b0;
            b_out       <= '0;
            b_vld_out   <= 1'b0;
            acc_q       <= '0;
            ovf         <= 1'b0;
            ps_out      <= '0;
            ps_vld_out  <= 1'b0;
            ps_last_out <= 1'b0;
            busy        <= 1'b0;
        end else begin
            a_out       <= a_in;
            a_vld_out   <= a_vld_in;
            b_out       <= b_in;
            b_vld_out   <= b_vld_in;
            acc_q       <= acc_d;
            ovf         <= ovf_d;
            ps_out      <= ps_d;
            ps_vld_out  <= ps_vld_d;
            ps_last_out <= ps_last_d;
            busy        <= (state_d != ST_ACC);
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench: single head PE, saturating/wrapping pair, and a 4-PE drain column.
module tb_systolic_mac_pe;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- head PE, ACC_W=24 ----------------
    logic [7:0]  a_h, b_h, a_out_h, b_out_h;
    logic        av_h, bv_h, clr_h, dr_h, av_out_h, bv_out_h;
    logic [23:0] ps_h;
    logic        psv_h, psl_h, busy_h, ovf_h;

    systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .MUL_STAGES(2), .SAT(1), .CHAIN_HEAD(1)) u_h (
        .clk(clk), .rst(rst), .a_in(a_h), .a_vld_in(av_h), .b_in(b_h), .b_vld_in(bv_h),
        .clr(clr_h), .drain_req(dr_h), .ps_in(24'd0), .ps_vld_in(1'b0), .ps_last_in(1'b0),
        .a_out(a_out_h), .a_vld_out(av_out_h), .b_out(b_out_h), .b_vld_out(bv_out_h),
        .ps_out(ps_h), .ps_vld_out(psv_h), .ps_last_out(psl_h), .busy(busy_h), .ovf(ovf_h));

    // ---------------- ACC_W=16 pair: saturate / wrap ----------------
    logic [7:0]  a_s, b_s;
    logic        av_s, bv_s, dr_s;
    logic [7:0]  ao_s1, bo_s1, ao_s0, bo_s0;
    logic        avo_s1, bvo_s1, avo_s0, bvo_s0;
    logic [15:0] ps_s1, ps_s0;
    logic        psv_s1, psl_s1, busy_s1, ovf_s1;
    logic        psv_s0, psl_s0, busy_s0, ovf_s0;

    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .MUL_STAGES(2), .SAT(1), .CHAIN_HEAD(1)) u_s1 (
        .clk(clk), .rst(rst), .a_in(a_s), .a_vld_in(av_s), .b_in(b_s), .b_vld_in(bv_s),
        .clr(1'b0), .drain_req(dr_s), .ps_in(16'd0), .ps_vld_in(1'b0), .ps_last_in(1'b0),
        .a_out(ao_s1), .a_vld_out(avo_s1), .b_out(bo_s1), .b_vld_out(bvo_s1),
        .ps_out(ps_s1), .ps_vld_out(psv_s1), .ps_last_out(psl_s1), .busy(busy_s1), .ovf(ovf_s1));

    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .MUL_STAGES(2), .SAT(0), .CHAIN_HEAD(1)) u_s0 (
        .clk(clk), .rst(rst), .a_in(a_s), .a_vld_in(av_s), .b_in(b_s), .b_vld_in(bv_s),
        .clr(1'b0), .drain_req(dr_s), .ps_in(16'd0), .ps_vld_in(1'b0), .ps_last_in(1'b0),
        .a_out(ao_s0), .a_vld_out(avo_s0), .b_out(bo_s0), .b_vld_out(bvo_s0),
        .ps_out(ps_s0), .ps_vld_out(psv_s0), .ps_last_out(psl_s0), .busy(busy_s0), .ovf(ovf_s0));

    // ---------------- 4-PE column, index 0 is the head ----------------
    logic [7:0]  a_c [4];
    logic [7:0]  b_c [4];
    logic [7:0]  ao_c [4];
    logic [7:0]  bo_c [4];
    logic        av_c [4];
    logic        bv_c [4];
    logic        avo_c [4];
    logic        bvo_c [4];
    logic        dr_c [4];
    logic        busy_c [4];
    logic        ovf_c [4];
    logic [23:0] ps_ch [5];
    logic        psv_ch [5];
    logic        psl_ch [5];

    assign ps_ch[0]  = '0;
    assign psv_ch[0] = 1'b0;
    assign psl_ch[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_col
        systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .MUL_STAGES(2), .SAT(1),
                          .CHAIN_HEAD((i == 0) ? 1 : 0)) u_pe (
            .clk(clk), .rst(rst), .a_in(a_c[i]), .a_vld_in(av_c[i]), .b_in(b_c[i]),
            .b_vld_in(bv_c[i]), .clr(1'b0), .drain_req(dr_c[i]), .ps_in(ps_ch[i]),
            .ps_vld_in(psv_ch[i]), .ps_last_in(psl_ch[i]), .a_out(ao_c[i]), .a_vld_out(avo_c[i]),
            .b_out(bo_c[i]), .b_vld_out(bvo_c[i]), .ps_out(ps_ch[i+1]), .ps_vld_out(psv_ch[i+1]),
            .ps_last_out(psl_ch[i+1]), .busy(busy_c[i]), .ovf(ovf_c[i]));
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fire_h(input logic [7:0] a, input logic [7:0] b);
        a_h = a; b_h = b; av_h = 1'b1; bv_h = 1'b1;
        tick();
        av_h = 1'b0; bv_h = 1'b0;
    endtask

    task automatic drain_h();
        dr_h = 1'b1;
        tick();
        dr_h = 1'b0;
        tick();
        tick();
    endtask

    task automatic set_all_dr_c(input logic v);
        for (int i = 0; i < 4; i++) dr_c[i] = v;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a_h = '0; b_h = '0; av_h = 0; bv_h = 0; clr_h = 0; dr_h = 0;
        a_s = '0; b_s = '0; av_s = 0; bv_s = 0; dr_s = 0;
        for (int i = 0; i < 4; i++) begin
            a_c[i] = '0; b_c[i] = '0; av_c[i] = 0; bv_c[i] = 0; dr_c[i] = 0;
        end

        // 1: reset holds everything at zero despite random activity
        for (int k = 0; k < 4; k++) begin
            a_h = 8'($urandom); b_h = 8'($urandom);
            av_h = 1'($urandom); bv_h = 1'($urandom);
            clr_h = 1'($urandom); dr_h = 1'($urandom);
            tick();
        end
        chk("rst_a_out", 64'(a_out_h), 0);
        chk("rst_b_out", 64'(b_out_h), 0);
        chk("rst_vlds", 64'({av_out_h, bv_out_h}), 0);
        chk("rst_ps_out", 64'(ps_h), 0);
        chk("rst_ps_flags", 64'({psv_h, psl_h, busy_h, ovf_h}), 0);
        chk("rst_col_psv", 64'(psv_ch[4]), 0);

        rst = 1'b0;
        clr_h = 0; dr_h = 0; bv_h = 0;
        a_h = 8'h5A; av_h = 1'b1; b_h = 8'hA5;
        tick();
        chk("fwd_a_out", 64'(a_out_h), 64'h5A);
        chk("fwd_a_vld", 64'(av_out_h), 1);
        chk("fwd_b_out", 64'(b_out_h), 64'hA5);
        chk("fwd_b_vld", 64'(bv_out_h), 0);
        av_h = 1'b0;
        tick();

        // 2: 3*4 + -2*5 + 7*7 = 51, result 3 cycles after drain_req
        fire_h(8'd3, 8'd4);
        fire_h(8'hFE, 8'd5);
        fire_h(8'd7, 8'd7);
        dr_h = 1'b1;
        tick();
        dr_h = 1'b0;
        chk("mac_busy_flush", 64'(busy_h), 1);
        chk("mac_vld_c1", 64'(psv_h), 0);
        tick();
        chk("mac_vld_c2", 64'(psv_h), 0);
        tick();
        chk("mac_ps_out", 64'($signed(ps_h)), 51);
        chk("mac_vld_last", 64'({psv_h, psl_h}), 3);
        tick();
        chk("mac_vld_after", 64'(psv_h), 0);
        chk("mac_busy_after", 64'(busy_h), 0);
        fire_h(8'd2, 8'd3);
        drain_h();
        chk("mac_fresh_acc", 64'($signed(ps_h)), 6);
        tick();

        // 4: clr coinciding with an arriving product keeps only that product
        fire_h(8'd10, 8'd10);
        fire_h(8'd2, 8'd3);
        tick();
        clr_h = 1'b1;
        tick();
        clr_h = 1'b0;
        drain_h();
        chk("clr_prod_ps", 64'($signed(ps_h)), 6);
        chk("clr_prod_vld", 64'(psv_h), 1);
        tick();

        // 5: operands fired during FLUSH are not accumulated
        fire_h(8'd5, 8'd5);
        dr_h = 1'b1;
        tick();
        dr_h = 1'b0;
        a_h = 8'd10; b_h = 8'd10; av_h = 1'b1; bv_h = 1'b1;
        tick();
        av_h = 1'b0; bv_h = 1'b0;
        tick();
        chk("flush_discard_ps", 64'($signed(ps_h)), 25);
        tick();
        tick();
        drain_h();
        chk("flush_discard_next", 64'($signed(ps_h)), 0);
        tick();

        // 3: 3 x 127*127 = 48387 saturates (16-bit) or wraps to -17149
        a_s = 8'd127; b_s = 8'd127; av_s = 1'b1; bv_s = 1'b1;
        tick();
        tick();
        chk("sat_ovf_early", 64'({ovf_s1, ovf_s0}), 0);
        tick();
        av_s = 1'b0; bv_s = 1'b0;
        tick();
        tick();
        chk("sat_ovf_set", 64'(ovf_s1), 1);
        chk("wrap_ovf_set", 64'(ovf_s0), 1);
        dr_s = 1'b1;
        tick();
        dr_s = 1'b0;
        tick();
        tick();
        chk("sat_ps_out", 64'($signed(ps_s1)), 32767);
        chk("wrap_ps_out", 64'($signed(ps_s0)), -17149);
        chk("sat_vld", 64'({psv_s1, psv_s0}), 3);
        chk("sat_ovf_clr", 64'({ovf_s1, ovf_s0}), 0);
        tick();

        // 6: column accs 1,2,3,4 drain bottom-first; drain_req in PASS ignored
        a_c[0] = 8'd1; b_c[0] = 8'd1;
        a_c[1] = 8'd1; b_c[1] = 8'd2;
        a_c[2] = 8'd1; b_c[2] = 8'd3;
        a_c[3] = 8'd2; b_c[3] = 8'd2;
        for (int i = 0; i < 4; i++) begin av_c[i] = 1'b1; bv_c[i] = 1'b1; end
        tick();
        for (int i = 0; i < 4; i++) begin av_c[i] = 1'b0; bv_c[i] = 1'b0; end
        set_all_dr_c(1'b1);
        tick();
        set_all_dr_c(1'b0);
        tick();
        tick();
        chk("col_w0", 64'($signed(ps_ch[4])), 4);
        chk("col_w0_flags", 64'({psv_ch[4], psl_ch[4]}), 2);
        tick();
        chk("col_w1", 64'($signed(ps_ch[4])), 3);
        chk("col_w1_flags", 64'({psv_ch[4], psl_ch[4]}), 2);
        dr_c[2] = 1'b1; dr_c[3] = 1'b1;
        tick();
        dr_c[2] = 1'b0; dr_c[3] = 1'b0;
        chk("col_w2", 64'($signed(ps_ch[4])), 2);
        chk("col_w2_flags", 64'({psv_ch[4], psl_ch[4]}), 2);
        tick();
        chk("col_w3", 64'($signed(ps_ch[4])), 1);
        chk("col_w3_flags", 64'({psv_ch[4], psl_ch[4]}), 3);
        tick();
        chk("col_vld_end", 64'(psv_ch[4]), 0);
        chk("col_busy_end", 64'({busy_c[0], busy_c[1], busy_c[2], busy_c[3]}), 0);

        // reset while the bottom PE is passing words
        set_all_dr_c(1'b1);
        tick();
        set_all_dr_c(1'b0);
        tick();
        tick();
        chk("col2_emit_vld", 64'(psv_ch[4]), 1);
        tick();
        chk("col2_pass_busy", 64'(busy_c[3]), 1);
        rst = 1'b1;
        tick();
        chk("col2_rst_vld", 64'(psv_ch[4]), 0);
        chk("col2_rst_busy", 64'(busy_c[3]), 0);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
